// File: rtl/fpu_pkg.sv
// Shared FPU core package: opcode width and the execution arbiter FSM states.
package fpu_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fpu_arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time goes first.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant_onehot,
    output logic       grant_idx
);

    // Combinational winner selection.
    always_comb begin
        grant_onehot = 2'b00;
        grant_idx    = 1'b0;
        case (req)
            2'b01: begin
                grant_onehot = 2'b01;
                grant_idx    = 1'b0;
            end
            2'b10: begin
                grant_onehot = 2'b10;
                grant_idx    = 1'b1;
            end
            2'b11: begin
                grant_idx    = ~last;
                grant_onehot = last ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fpu_exec_arbiter.sv
// Shares one FPU execution element between two requesters.
// State | meaning
// IDLE  | waiting for a request, req_ready follows the arbitration winner
// START | one cycle with elem_start high to reset/launch the element
// WAIT  | counting cycles until elem_completed or timeout
// RESP  | result presented until the consumer takes it
module fpu_exec_arbiter
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0][OPC_W-1:0]       req_inst_num,
    input  logic [1:0][31:0]            req_fs,
    input  logic [1:0][31:0]            req_ft,
    input  logic [1:0][TAG_W-1:0]       req_tag,
    output logic                        elem_start,
    output logic [OPC_W-1:0]            elem_inst_num,
    output logic [31:0]                 elem_fs,
    output logic [31:0]                 elem_ft,
    input  logic                        elem_completed,
    input  logic [31:0]                 elem_out,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_id,
    output logic [TAG_W-1:0]            resp_tag,
    output logic [31:0]                 resp_data,
    output logic                        resp_err,
    output logic                        busy
);

    // One spare bit so the counter can never wrap before the timeout compare fires.
    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fpu_arb_state_e     state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [OPC_W-1:0]   inst_q, inst_d;
    logic [31:0]        fs_q, fs_d;
    logic [31:0]        ft_q, ft_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;

    logic [1:0]         grant_onehot;
    logic               grant_idx;
    logic               accept;
    logic               timeout_hit;

    rr_arbiter2 u_rr (
        .req          (req_valid),
        .last         (last_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign accept      = |(req_valid & req_ready);
    assign timeout_hit = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; completion is ignored in START because it may be stale.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (elem_completed || timeout_hit) state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, all decoded from the registered state.
    always_comb begin
        req_ready  = (state_q == ST_IDLE) ? grant_onehot : 2'b00;
        elem_start = (state_q == ST_START);
        resp_valid = (state_q == ST_RESP);
        busy       = (state_q != ST_IDLE);
    end

    // Datapath next values: capture on acceptance, result capture when WAIT ends.
    always_comb begin
        last_d = last_q;
        id_d   = id_q;
        tag_d  = tag_q;
        inst_d = inst_q;
        fs_d   = fs_q;
        ft_d   = ft_q;
        data_d = data_q;
        err_d  = err_q;
        cnt_d  = '0;
        if (accept) begin
            last_d = grant_idx;
            id_d   = grant_idx;
            tag_d  = req_tag[grant_idx];
            inst_d = req_inst_num[grant_idx];
            fs_d   = req_fs[grant_idx];
            ft_d   = req_ft[grant_idx];
        end
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (elem_completed) begin
                data_d = elem_out;
                err_d  = 1'b0;
            end else if (timeout_hit) begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
    end

    // Datapath registers; last grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
            cnt_q  <= '0;
            id_q   <= 1'b0;
            tag_q  <= '0;
            inst_q <= '0;
            fs_q   <= '0;
            ft_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
            id_q   <= id_d;
            tag_q  <= tag_d;
            inst_q <= inst_d;
            fs_q   <= fs_d;
            ft_q   <= ft_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign elem_inst_num = inst_q;
    assign elem_fs       = fs_q;
    assign elem_ft       = ft_q;
    assign resp_id       = id_q;
    assign resp_tag      = tag_q;
    assign resp_data     = data_q;
    assign resp_err      = err_q;

endmodule

// File: tb/tb_fpu_exec_arbiter.sv
// Bench for fpu_exec_arbiter with a behavioural exec element of programmable latency.
module tb_fpu_exec_arbiter;

    localparam int TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [1:0]            req_valid = '0;
    logic [1:0]            req_ready;
    logic [1:0][5:0]       req_inst_num = '0;
    logic [1:0][31:0]      req_fs = '0;
    logic [1:0][31:0]      req_ft = '0;
    logic [1:0][TAG_W-1:0] req_tag = '0;
    logic                  elem_start;
    logic [5:0]            elem_inst_num;
    logic [31:0]           elem_fs, elem_ft;
    logic                  elem_completed;
    logic [31:0]           elem_out;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic                  resp_id;
    logic [TAG_W-1:0]      resp_tag;
    logic [31:0]           resp_data;
    logic                  resp_err;
    logic                  busy;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Element model: cleared while elem_start is high, done after lat cycles (lat=0: never).
    logic [7:0]  lat = 8'd2;
    logic [7:0]  ecnt = 8'd0;
    logic        mdone = 1'b0;
    logic [31:0] mout = 32'd0;
    logic        ovr_en = 1'b0, ovr_val = 1'b0;
    logic [31:0] ovr_data = 32'd0;

    function automatic logic [31:0] elem_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + {26'd0, op};
    endfunction

    always @(posedge clk) begin
        if (elem_start) begin
            ecnt  <= 8'd0;
            mdone <= 1'b0;
        end else if (!mdone && lat != 8'd0) begin
            ecnt <= 8'(ecnt + 8'd1);
            if (8'(ecnt + 8'd1) == lat) begin
                mdone <= 1'b1;
                mout  <= elem_fn(elem_inst_num, elem_fs, elem_ft);
            end
        end
    end

    assign elem_completed = ovr_en ? ovr_val : mdone;
    assign elem_out       = ovr_en ? ovr_data : mout;

    always #5 clk = ~clk;

    fpu_exec_arbiter #(.TIMEOUT(64), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_inst_num(req_inst_num), .req_fs(req_fs), .req_ft(req_ft), .req_tag(req_tag),
        .elem_start(elem_start), .elem_inst_num(elem_inst_num), .elem_fs(elem_fs), .elem_ft(elem_ft),
        .elem_completed(elem_completed), .elem_out(elem_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges after the handshake edge until resp_valid, or -1.
    task automatic wait_resp(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (resp_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        req_valid  = '0;
        resp_ready = 1'b0;
        ovr_en     = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tot_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        tot_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else pass_cnt++;
        tot_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b want 00", req_ready); else pass_cnt++;
        tot_cnt++; if (elem_start !== 1'b0) $display("FAIL reset_elem_start got %b want 0", elem_start); else pass_cnt++;
        tot_cnt++; if ({resp_data, resp_tag, resp_err, resp_id} !== '0) $display("FAIL reset_resp_fields got %h/%h/%b/%b want 0", resp_data, resp_tag, resp_err, resp_id); else pass_cnt++;
        tot_cnt++; if ({elem_fs, elem_ft, elem_inst_num} !== '0) $display("FAIL reset_operands got %h/%h/%h want 0", elem_fs, elem_ft, elem_inst_num); else pass_cnt++;
    endtask

    task automatic test_single();
        int n;
        do_reset();
        lat = 8'd2;
        req_inst_num[0] = 6'd5;
        req_fs[0] = 32'h3F80_0000;
        req_ft[0] = 32'h4000_0000;
        req_tag[0] = 4'd3;
        req_valid = 2'b01;
        #1;
        tot_cnt++; if (req_ready !== 2'b01) $display("FAIL single_ready got %b want 01", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        tot_cnt++; if ({elem_start, busy} !== 2'b11) $display("FAIL single_start got %b want 11", {elem_start, busy}); else pass_cnt++;
        tot_cnt++; if ({elem_fs, elem_ft} !== {32'h3F80_0000, 32'h4000_0000}) $display("FAIL single_operands got %h %h want 3f800000 40000000", elem_fs, elem_ft); else pass_cnt++;
        wait_resp(20, n);
        tot_cnt++; if (n !== 4) $display("FAIL single_latency got %0d want 4", n); else pass_cnt++;
        tot_cnt++; if (elem_start !== 1'b0) $display("FAIL single_start_low got %b want 0", elem_start); else pass_cnt++;
        tot_cnt++; if ({resp_id, resp_tag, resp_err} !== {1'b0, 4'd3, 1'b0}) $display("FAIL single_id_tag_err got %b/%h/%b want 0/3/0", resp_id, resp_tag, resp_err); else pass_cnt++;
        tot_cnt++; if (resp_data !== 32'h4040_0000) $display("FAIL single_data got %h want 40400000", resp_data); else pass_cnt++;
        consume();
        tot_cnt++; if (elem_fs !== 32'h3F80_0000) $display("FAIL single_operand_hold got %h want 3f800000", elem_fs); else pass_cnt++;
    endtask

    task automatic test_tie();
        int n;
        int last = 1;
        int exp;
        do_reset();
        lat = 8'd2;
        for (int i = 0; i < 2; i++) begin
            req_inst_num[i] = 6'($urandom);
            req_fs[i] = $urandom;
            req_ft[i] = $urandom;
            req_tag[i] = 4'(i + 6);
        end
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        #1;
        for (int op = 0; op < 4; op++) begin
            exp = 1 - last;
            tot_cnt++; if (req_ready !== (exp == 1 ? 2'b10 : 2'b01)) $display("FAIL tie_grant op%0d got %b want idx %0d", op, req_ready, exp); else pass_cnt++;
            tick();
            last = exp;
            wait_resp(20, n);
            tot_cnt++; if (n !== 4 || resp_id !== 1'(exp) || resp_data !== elem_fn(req_inst_num[exp], req_fs[exp], req_ft[exp]))
                $display("FAIL tie_resp op%0d got n=%0d id=%b data=%h want n=4 id=%0d", op, n, resp_id, resp_data, exp);
            else pass_cnt++;
            tick();
        end
        req_valid  = 2'b00;
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] exp_data;
        do_reset();
        lat = 8'd3;
        req_inst_num[1] = 6'd17;
        req_fs[1] = 32'h1234_5678;
        req_ft[1] = 32'h9ABC_DEF0;
        req_tag[1] = 4'd9;
        exp_data = elem_fn(6'd17, 32'h1234_5678, 32'h9ABC_DEF0);
        req_valid = 2'b10;
        #1;
        tick();
        req_valid = 2'b11;
        wait_resp(20, n);
        tot_cnt++; if (n !== 5) $display("FAIL bp_latency got %0d want 5", n); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            tot_cnt++; if ({resp_valid, req_ready, resp_id, resp_tag, resp_data} !== {1'b1, 2'b00, 1'b1, 4'd9, exp_data})
                $display("FAIL bp_hold cyc%0d got v=%b rdy=%b id=%b tag=%h data=%h want 1/00/1/9/%h", k, resp_valid, req_ready, resp_id, resp_tag, resp_data, exp_data);
            else pass_cnt++;
            tick();
        end
        resp_ready = 1'b1;
        #1;
        tot_cnt++; if (req_ready !== 2'b00) $display("FAIL bp_same_cycle_ready got %b want 00", req_ready); else pass_cnt++;
        tick();
        resp_ready = 1'b0;
        tot_cnt++; if ({busy, resp_valid, req_ready} !== {1'b0, 1'b0, 2'b01}) $display("FAIL bp_after_release got busy=%b v=%b rdy=%b want 0/0/01", busy, resp_valid, req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        tot_cnt++; if (busy !== 1'b1) $display("FAIL bp_next_accept got busy=%b want 1", busy); else pass_cnt++;
        wait_resp(20, n);
        consume();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        lat = 8'd0;
        ovr_en = 1'b1;
        ovr_val = 1'b0;
        ovr_data = 32'hCAFE_F00D;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        wait_resp(100, n);
        tot_cnt++; if (n !== 65) $display("FAIL timeout_latency got %0d want 65", n); else pass_cnt++;
        tot_cnt++; if ({resp_err, resp_data} !== {1'b1, 32'd0}) $display("FAIL timeout_result got err=%b data=%h want 1/0", resp_err, resp_data); else pass_cnt++;
        consume();
        req_valid = 2'b10;
        #1;
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 64; k++) tick();
        tot_cnt++; if (resp_valid !== 1'b0) $display("FAIL timeout_early got %b want 0", resp_valid); else pass_cnt++;
        ovr_val = 1'b1;
        tick();
        tot_cnt++; if ({resp_valid, resp_err, resp_data} !== {1'b1, 1'b0, 32'hCAFE_F00D}) $display("FAIL timeout_last_cycle_complete got v=%b err=%b data=%h want 1/0/cafef00d", resp_valid, resp_err, resp_data); else pass_cnt++;
        consume();
        ovr_en = 1'b0;
        ovr_val = 1'b0;
    endtask

    task automatic test_stale();
        int n;
        lat = 8'd2;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        wait_resp(20, n);
        consume();
        lat = 8'd3;
        req_valid = 2'b10;
        #1;
        tick();
        req_valid = 2'b00;
        wait_resp(20, n);
        tot_cnt++; if (n !== 5) $display("FAIL stale_completion got latency %0d want 5", n); else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        do_reset();
        lat = 8'd0;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        tot_cnt++; if ({busy, resp_valid, elem_start} !== 3'b000) $display("FAIL rst_mid_wait_state got busy=%b v=%b start=%b want 000", busy, resp_valid, elem_start); else pass_cnt++;
        tot_cnt++; if ({elem_fs, elem_ft, resp_tag} !== '0) $display("FAIL rst_mid_wait_regs got %h/%h/%h want 0", elem_fs, elem_ft, resp_tag); else pass_cnt++;
        #1;
        reset = 1'b0;
        lat = 8'd2;
        tick();
        tick();
        tot_cnt++; if ({busy, resp_valid} !== 2'b00) $display("FAIL rst_no_resp got busy=%b v=%b want 00", busy, resp_valid); else pass_cnt++;
        req_valid = 2'b11;
        #1;
        tot_cnt++; if (req_ready !== 2'b01) $display("FAIL rst_tie_grant got %b want 01", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        wait_resp(20, n);
        tot_cnt++; if (n !== 4 || resp_id !== 1'b0) $display("FAIL rst_tie_resp got n=%0d id=%b want 4/0", n, resp_id); else pass_cnt++;
        consume();
    endtask

    task automatic test_random();
        int n, exp, bp, l;
        int last = 1;
        logic [1:0] v;
        logic [31:0] exp_data;
        do_reset();
        for (int op = 0; op < 24; op++) begin
            v = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                req_inst_num[i] = 6'($urandom);
                req_fs[i] = $urandom;
                req_ft[i] = $urandom;
                req_tag[i] = 4'($urandom);
            end
            l = $urandom_range(1, 6);
            lat = 8'(l);
            exp = (v == 2'b11) ? 1 - last : (v == 2'b10 ? 1 : 0);
            exp_data = elem_fn(req_inst_num[exp], req_fs[exp], req_ft[exp]);
            req_valid = v;
            #1;
            tot_cnt++; if (req_ready !== (exp == 1 ? 2'b10 : 2'b01)) $display("FAIL rand_grant op%0d got %b want idx %0d", op, req_ready, exp); else pass_cnt++;
            tick();
            last = exp;
            req_valid = 2'b00;
            wait_resp(20, n);
            tot_cnt++; if (n !== 2 + l || resp_id !== 1'(exp) || resp_tag !== req_tag[exp] || resp_data !== exp_data || resp_err !== 1'b0)
                $display("FAIL rand_resp op%0d got n=%0d id=%b tag=%h data=%h err=%b want n=%0d id=%0d tag=%h data=%h err=0",
                         op, n, resp_id, resp_tag, resp_data, resp_err, 2 + l, exp, req_tag[exp], exp_data);
            else pass_cnt++;
            bp = $urandom_range(0, 3);
            for (int k = 0; k < bp; k++) tick();
            tot_cnt++; if (resp_valid !== 1'b1 || resp_data !== exp_data) $display("FAIL rand_hold op%0d got v=%b data=%h want 1/%h", op, resp_valid, resp_data, exp_data); else pass_cnt++;
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_timeout();
        test_stale();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/fpu_exec_arbiter.md
FPU_EXEC_ARBITER -- requirements
Module: fpu_exec_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 64, the maximum WAIT cycles before abort; TAG_W, default 4, the requester tag width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
REQ-003 Requester ports SHALL be:
- req_valid  in  2  request per requester (index 0, 1).
- req_ready  out  2  grant/accept per requester.
- req_inst_num  in  2x6  opcode per requester.
- req_fs, req_ft  in  2x32  operands per requester.
- req_tag  in  2xTAG_W  opaque tag per requester.
REQ-004 Element ports SHALL be:
- elem_start  out  1  drives the exec element's reset input.
- elem_inst_num  out  6  latched opcode.
- elem_fs, elem_ft  out  32  latched operands.
- elem_completed  in  1  element done flag.
- elem_out  in  32  element result.
REQ-005 Response ports SHALL be:
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts.
- resp_id  out  1  winning requester.
- resp_tag  out  TAG_W  tag of the winning request.
- resp_data  out  32  result.
- resp_err  out  1  timeout abort.
- busy  out  1  state is not IDLE.

Function
REQ-010 The FSM SHALL have exactly four states, IDLE, START, WAIT and RESP, encoded in an enum.
REQ-011 In IDLE, req_ready SHALL be asserted combinationally only for the arbitration winner; req_ready SHALL be 2'b00 in every other state.
REQ-012 Arbitration SHALL be round-robin:
- if both requests are valid, the winner is the index != last_grant;
- if one request is valid, it wins;
- last_grant resets to 1, so requester 0 wins the first tie.
REQ-013 A handshake (req_valid[i] & req_ready[i]) SHALL latch inst_num, fs, ft, tag and id, update last_grant to i, and move IDLE->START.
REQ-014 START SHALL last exactly 1 cycle, with elem_start=1, then move to WAIT; elem_start SHALL be 0 in all other states.
REQ-015 elem_completed SHALL be ignored in START, because it may still hold the previous operation's value.
REQ-016 In WAIT, a cycle counter SHALL start at 0 and increment each cycle.
- If elem_completed=1, latch resp_data=elem_out and resp_err=0, then go to RESP.
- Else if counter==TIMEOUT-1, latch resp_data=0 and resp_err=1, then go to RESP.
- If both hold in the same cycle, completion SHALL win.
REQ-017 The counter SHALL be $clog2(TIMEOUT)+1 bits wide and SHALL NOT wrap before the timeout fires.
REQ-018 RESP SHALL assert resp_valid=1. resp_data, resp_tag, resp_id and resp_err SHALL be held stable while resp_valid=1 and resp_ready=0.
REQ-019 RESP SHALL move to IDLE on resp_ready=1. A new request SHALL NOT be accepted in that same cycle; the earliest next acceptance is the following cycle.
REQ-020 With a 2-cycle element, resp_valid SHALL rise 4 cycles after the request handshake edge: START (1) + WAIT (2) + registered RESP.
REQ-021 elem_inst_num, elem_fs and elem_ft SHALL hold the latched values from START until the next acceptance.
REQ-022 busy SHALL be 1 in START, WAIT and RESP.

Reset
REQ-030 Asserting reset at any time, including mid-WAIT or mid-RESP, SHALL asynchronously force:
- state=IDLE, last_grant=1, counter=0;
- resp_valid=0, resp_err=0, resp_data=0, resp_tag=0, resp_id=0;
- elem_start=0, latched operands=0, busy=0.
REQ-031 Any in-flight operation SHALL be discarded on reset, with no response issued.

Structure
REQ-040 The state enum and the opcode width constant (6) SHALL live in the shared core package fpu_pkg.
REQ-041 The round-robin pick SHALL be one sub-module, rr_arbiter2: inputs req[1:0] and last; outputs grant_onehot and grant_idx.
REQ-042 Everything else SHALL be flat in fpu_exec_arbiter; the exec element SHALL be instantiated only by the bench and by the parent, not inside this block.

Verification
REQ-050 Single request: req0 with fs=0x3F800000, ft=0x40000000, tag=3, and a 2-cycle element model returning 0x40400000 -> resp_valid 4 cycles after the handshake, resp_id=0, resp_tag=3, resp_data=0x40400000, resp_err=0.
REQ-051 Tie: both requests valid from reset, resp_ready=1 -> grants in the order 0,1,0,1 over four operations.
REQ-052 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data held; req_ready=00 throughout; no grant until the cycle after resp_ready=1.
REQ-053 Timeout: elem_completed held 0 -> resp_err=1 and resp_data=0 after exactly 64 WAIT cycles. Then: elem_completed=1 in the 64th WAIT cycle -> resp_err=0.
REQ-054 Stale completion: elem_completed=1 during START -> no early exit to RESP.
REQ-055 Reset mid-WAIT: async reset pulse between clock edges -> immediate IDLE, busy=0, no resp_valid; then a next tie is granted to requester 0.
